// File: rtl/idexe_pkg.sv
// Shared types and constants for the ID->EX pipeline register.
// Optional load-use stall is enabled by defining IDEXE_LOADUSE_STALL_EN.
package idexe_pkg;

  localparam int unsigned DefXlen  = 32;
  localparam int unsigned DefRegAw = 5;
  localparam int unsigned DefAlucW = 4;

  // ALU operation encodings driven on aluc
  localparam logic [DefAlucW-1:0] ALUC_ADD = 4'b0000;
  localparam logic [DefAlucW-1:0] ALUC_AND = 4'b0001;
  localparam logic [DefAlucW-1:0] ALUC_XOR = 4'b0010;
  localparam logic [DefAlucW-1:0] ALUC_SLL = 4'b0011;
  localparam logic [DefAlucW-1:0] ALUC_SUB = 4'b0100;
  localparam logic [DefAlucW-1:0] ALUC_OR  = 4'b0101;
  localparam logic [DefAlucW-1:0] ALUC_LUI = 4'b0110;
  localparam logic [DefAlucW-1:0] ALUC_SRL = 4'b0111;
  localparam logic [DefAlucW-1:0] ALUC_SRA = 4'b1111;

  typedef struct packed {
    logic                wreg;
    logic                m2reg;
    logic                wmem;
    logic                aluimm;
    logic [DefAlucW-1:0] aluc;
  } idexe_ctrl_t;

  // A load writes its destination from memory, so m2reg marks it.
  function automatic logic is_load(input logic m2reg, input logic wreg);
    return m2reg & wreg;
  endfunction

endpackage

// File: rtl/idexe_hazard_detect.sv
// Load-use hazard compare between the EX-stage entry and the instruction in ID.
module idexe_hazard_detect
  import idexe_pkg::*;
#(
  parameter int unsigned REG_AW = DefRegAw
) (
  input  logic              ex_valid_i,
  input  logic              ex_m2reg_i,
  input  logic [REG_AW-1:0] ex_dest_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_uses_rt_i,
  output logic              hazard_o
);

  logic dest_nz;
  logic rs_hit;
  logic rt_hit;

  // $0 is never written, so a load into it cannot create a dependency.
  assign dest_nz  = |ex_dest_i;
  assign rs_hit   = (ex_dest_i == id_rs_i);
  assign rt_hit   = id_uses_rt_i && (ex_dest_i == id_rt_i);
  assign hazard_o = ex_valid_i && ex_m2reg_i && dest_nz && (rs_hit || rt_hit);

endmodule

// File: rtl/idexe_stage_reg.sv
// ID->EX pipeline register with valid/ready handshake, two-entry skid buffer and flush.
// Define IDEXE_LOADUSE_STALL_EN to insert one bubble behind each dependent load.
module idexe_stage_reg
  import idexe_pkg::*;
#(
  parameter int unsigned XLEN   = DefXlen,
  parameter int unsigned REG_AW = DefRegAw,
  parameter int unsigned ALUC_W = DefAlucW
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wreg,
  input  logic              in_m2reg,
  input  logic              in_wmem,
  input  logic              in_aluimm,
  input  logic [ALUC_W-1:0] in_aluc,
  input  logic [REG_AW-1:0] in_dest,
  input  logic [REG_AW-1:0] in_rs,
  input  logic [REG_AW-1:0] in_rt,
  input  logic              in_uses_rt,
  input  logic [XLEN-1:0]   in_qa,
  input  logic [XLEN-1:0]   in_qb,
  input  logic [XLEN-1:0]   in_imm32,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              ewreg,
  output logic              em2reg,
  output logic              ewmem,
  output logic              ealuimm,
  output logic [ALUC_W-1:0] ealuc,
  output logic [REG_AW-1:0] edest,
  output logic [XLEN-1:0]   eqa,
  output logic [XLEN-1:0]   eqb,
  output logic [XLEN-1:0]   eimm32
);

  typedef struct packed {
    logic              wreg;
    logic              m2reg;
    logic              wmem;
    logic              aluimm;
    logic [ALUC_W-1:0] aluc;
    logic [REG_AW-1:0] dest;
    logic [XLEN-1:0]   qa;
    logic [XLEN-1:0]   qb;
    logic [XLEN-1:0]   imm;
  } payload_t;

  payload_t in_pl;
  payload_t main_q, main_d;
  payload_t skid_q, skid_d;
  logic     main_v_q, main_v_d;
  logic     skid_v_q, skid_v_d;

  logic hazard;
  logic accept;
  logic consume;
  logic main_free;

  assign in_pl = '{
    wreg:   in_wreg,
    m2reg:  in_m2reg,
    wmem:   in_wmem,
    aluimm: in_aluimm,
    aluc:   in_aluc,
    dest:   in_dest,
    qa:     in_qa,
    qb:     in_qb,
    imm:    in_imm32
  };

`ifdef IDEXE_LOADUSE_STALL_EN
  idexe_hazard_detect #(
    .REG_AW(REG_AW)
  ) u_hazard_detect (
    .ex_valid_i  (main_v_q),
    .ex_m2reg_i  (main_q.m2reg),
    .ex_dest_i   (main_q.dest),
    .id_rs_i     (in_rs),
    .id_rt_i     (in_rt),
    .id_uses_rt_i(in_uses_rt),
    .hazard_o    (hazard)
  );
`else
  logic unused_srcs;

  assign hazard      = 1'b0;
  assign unused_srcs = ^{in_rs, in_rt, in_uses_rt};
`endif

  assign in_ready  = !skid_v_q && !hazard;
  assign accept    = in_valid && in_ready;
  assign consume   = main_v_q && out_ready;
  assign main_free = !main_v_q || consume;

  always_comb begin
    main_d   = main_q;
    skid_d   = skid_q;
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    if (flush) begin
      // Squash wins over accept; payload is left untouched so data fields hold.
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (skid_v_q) begin
      if (consume) begin
        main_d   = skid_q;
        skid_v_d = 1'b0;
      end
    end else if (accept) begin
      if (main_free) begin
        main_d   = in_pl;
        main_v_d = 1'b1;
      end else begin
        skid_d   = in_pl;
        skid_v_d = 1'b1;
      end
    end else if (consume) begin
      main_v_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
    end
  end

  // Side-effecting controls are gated so a bubble never writes state downstream.
  assign out_valid = main_v_q;
  assign ewreg     = main_v_q & main_q.wreg;
  assign em2reg    = main_v_q & main_q.m2reg;
  assign ewmem     = main_v_q & main_q.wmem;
  assign ealuimm   = main_q.aluimm;
  assign ealuc     = main_q.aluc;
  assign edest     = main_q.dest;
  assign eqa       = main_q.qa;
  assign eqb       = main_q.qb;
  assign eimm32    = main_q.imm;

  // Skid only ever fills behind an occupied main register.
  a_no_skid_without_main: assert property (
    @(posedge clock) disable iff (!resetn) !(skid_v_q && !main_v_q)
  );

endmodule

// File: doc/idexe_stage_reg.md
# idexe_stage_reg

Parametrised ID→EX pipeline register for the MIPS pipeline, successor to the fixed-width unconditional ID/EX latch. Adds a valid/ready handshake with a two-entry skid buffer, a synchronous flush for branch/jump squash, and bubble insertion. When `IDEXE_LOADUSE_STALL_EN` is defined, it also detects load-use hazards and stalls. It sits between the decode/register-file stage and the ALU stage.

## Interface
Parameters:
- `XLEN`, default 32, datapath width (`qa`, `qb`, `imm`).
- `REG_AW`, default 5, register address width.
- `ALUC_W`, default 4, ALU control width.

Ports:
- `clock`, in, 1: rising-edge clock.
- `resetn`, in, 1: one clock; reset is asynchronous and active-low.
- `flush`, in, 1: squash all held and incoming entries.
- `in_valid`, in, 1: ID presents an instruction.
- `in_ready`, out, 1: stage can accept.
- `in_wreg`, `in_m2reg`, `in_wmem`, `in_aluimm`, in, 1 each: decoded controls.
- `in_aluc`, in, `ALUC_W`: ALU operation.
- `in_dest`, `in_rs`, `in_rt`, in, `REG_AW` each: destination and source register numbers.
- `in_uses_rt`, in, 1: the instruction reads `rt`.
- `in_qa`, `in_qb`, `in_imm32`, in, `XLEN` each: operands.
- `out_valid`, out, 1: EX entry valid.
- `out_ready`, in, 1: EX consumes the entry this cycle.
- `ewreg`, `em2reg`, `ewmem`, `ealuimm`, `ealuc`, `edest`, `eqa`, `eqb`, `eimm32`, out, widths matching their inputs: registered payload.

## Operation
- Storage is a main register (drives the outputs) plus one skid register, each with its own valid bit.
- `in_ready = !skid_valid && !hazard`. It is combinational, with no dependence on `in_valid`.
- Accept occurs when `in_valid && in_ready`. Routing depends on the main register:
  - If main is empty or consumed this cycle (`out_valid && out_ready`), the accepted entry loads main.
  - Otherwise it loads skid.
- Consume with skid full: skid moves to main and skid empties.
- Consume with no accept and skid empty: main becomes a bubble.
- While `out_valid`=0, the outputs `ewreg`, `em2reg` and `ewmem` read 0. Data fields hold their last value. A bubble therefore never writes a register or memory.
- `flush`:
  - Clears both valid bits at the next edge.
  - Discards any entry accepted in the same cycle; flush wins over accept.
  - A consume by EX in the flush cycle still counts as having taken the old main entry.
- Hazard (macro only): `hazard = out_valid && em2reg && edest!=0 && (edest==in_rs || (in_uses_rt && edest==in_rt))`.
  - When `hazard` is set, `in_ready`=0. If `out_ready`, main becomes a bubble and the hazard clears on the next cycle.
- No state machine beyond the two valid bits. The legal states are (main, skid) = 00, 10, 11. State 01 is unreachable and is flagged by an assertion.

## Timing
- Reset (async): both valid bits 0; every output 0 except `in_ready`=1.
- Latency: 1 cycle from accept to `out_valid` when main is free.
- Throughput: 1 entry per cycle with `out_ready` held high.
- Back-pressure: at most one extra entry is absorbed after `out_ready` falls. `in_ready` drops the cycle after skid fills, as a registered effect.
- Load-use: exactly one bubble is inserted when `out_ready`=1. The stall persists while `out_ready`=0.
- Reset asserted mid-transfer: contents are lost; no entry reappears after release.

## Configuration
- Macro: `IDEXE_LOADUSE_STALL_EN`.
- Defined: `hazard` is computed as above and one bubble is inserted behind each dependent load.
- Undefined: `hazard` is tied to 0. `in_rs`, `in_rt` and `in_uses_rt` are unused, and forwarding or software is responsible for correctness.

## Structure
- Package `idexe_pkg`: `idexe_ctrl_t` struct (wreg, m2reg, wmem, aluimm, aluc), the `ALUC_*` opcode constants and the default widths.
- Sub-module `idexe_hazard_detect`: combinational load-use compare, instantiated only under the macro.
- Main and skid registers each hold a full payload struct.

## Test plan
- **Reset:** drive `resetn`=0 mid-stream → all outputs 0, `in_ready`=1, `out_valid`=0 until the first accept.
- **Streaming:** 8 back-to-back entries (`qa`=1..8) with `out_ready`=1 → `eqa` shows 1..8 on consecutive cycles, each one cycle after its accept.
- **Back-pressure:** `out_ready`=0 for 3 cycles during streaming → `in_ready` falls after the skid fills. No entry is lost or duplicated, and the order is preserved.
- **Flush:** `flush` with both registers full plus a simultaneous accept → next cycle `out_valid`=0, `ewreg`=0, `ewmem`=0, `in_ready`=1.
- **Load-use (macro on):** `lw $3` followed by `add $4,$3,$5` → one bubble with `ewreg`=0 between them.
- **Load-use boundary (macro on):** `lw $0` followed by a dependent instruction → no bubble.
- **Macro off:** the same `lw $3` / `add $4,$3,$5` sequence → no bubble.
